axis_pattern_gen: RTL and testbench

// - Parametrised AXI4-Stream test-traffic source; next-generation replacement for the fixed 11-beat sender.
// - Emits a configurable number of bursts with programmable length, inter-burst gap, partial last beat
//   and selectable data pattern. Feeds the Aurora TX user interface for link bring-up and BER runs.
// - Fully AXIS compliant: tvalid never depends on tready; payload is held stable while stalled.

---
 rtl/axis_pattern_gen_pkg.sv | 30 +++
 rtl/axis_pattern_gen_if.sv | 34 +++
 rtl/axis_pattern_gen_prbs31_gen.sv | 39 +++
 rtl/axis_pattern_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pattern_pkg
// Description : Shared constants for the AXI4-Stream pattern generator.
//               Holds the pattern mode codes, the FSM state encoding and the
//               PRBS31 tap positions.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pattern_pkg;

    // Pattern select codes presented on cfg_mode
    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_WALK1 = 2'd1;
    localparam logic [1:0] MODE_PRBS  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    // Run-control FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // x^31 + x^28 + 1 expressed as zero-based state bit indices
    localparam int PRBS_TAP_HI = 30;
    localparam int PRBS_TAP_LO = 27;

endpackage
`default_nettype wire

// File: rtl/axis_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_pattern_gen_if
// Description : AXI4-Stream bundle used by the pattern generator.
//               master: drives tvalid/tdata/tkeep/tlast, samples tready.
//               slave : samples payload, drives tready.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_pattern_gen_if #(
    parameter int DATA_W = 256
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_pattern_gen_prbs31_gen.sv
`default_nettype none
// ============================================================================
// Module      : prbs31_gen
// Description : 32-bit Fibonacci LFSR implementing x^31 + x^28 + 1.
//               Ports: clk, rst (sync, active-high), seed_load (reload SEED),
//               advance (one step), state (current 32-bit register).
// Revision    : 1.0 - initial release
// ============================================================================
module prbs31_gen
    import axis_pattern_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        seed_load,
    input  wire logic        advance,
    output logic [31:0]      state
);

    logic [31:0] r_state;
    logic        w_fb;

    assign w_fb = r_state[PRBS_TAP_HI] ^ r_state[PRBS_TAP_LO];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (seed_load) begin
            r_state <= SEED;
        end else if (advance) begin
            r_state <= {r_state[30:0], w_fb};
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/axis_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : axis_pattern_gen
// Description : AXI4-Stream test-traffic source. Emits bursts of programmable
//               length, gap and partial last beat carrying an INC, WALK1,
//               PRBS31 or constant pattern.
// Ports       : axis_aclk/axis_areset - clock, sync active-high reset
//               start/stop            - run request (edge) / graceful stop
//               cfg_*                 - run configuration, sampled at start
//               axis                  - AXIS master bundle
//               busy/done/beat_total  - run status
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pattern_gen
    import axis_pattern_pkg::*;
#(
    parameter int          DATA_W    = 256,
    parameter logic [31:0] SEED      = 32'h0000_0001,
    parameter logic [31:0] CONST_PAT = 32'hA5A5_5A5A
) (
    input  wire logic                        axis_aclk,
    input  wire logic                        axis_areset,
    input  wire logic                        start,
    input  wire logic                        stop,
    input  wire logic [1:0]                  cfg_mode,
    input  wire logic [15:0]                 cfg_burst_len,
    input  wire logic [15:0]                 cfg_num_bursts,
    input  wire logic [7:0]                  cfg_gap,
    input  wire logic [$clog2(DATA_W/8):0]   cfg_last_bytes,
    axis_pattern_gen_if.master               axis,
    output logic                             busy,
    output logic                             done,
    output logic [31:0]                      beat_total
);

    localparam int KEEP_W  = DATA_W / 8;
    localparam int LB_W    = $clog2(KEEP_W) + 1;
    localparam int N_WORDS = DATA_W / 32;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_start_d;
    logic [1:0]          r_mode;
    logic [15:0]         r_len;
    logic [15:0]         r_num;
    logic [7:0]          r_gap;
    logic [LB_W-1:0]     r_last_bytes;

    logic [15:0]         r_beat_cnt;     // 1-based position inside current burst
    logic [15:0]         r_burst_idx;    // 1-based index of current burst
    logic [7:0]          r_gap_cnt;      // remaining idle cycles minus one
    logic [31:0]         r_inc;
    logic [DATA_W-1:0]   r_walk;
    logic [31:0]         r_beat_total;
    logic [31:0]         w_prbs;

    logic                w_start_edge;
    logic                w_launch;
    logic                w_hs;
    logic                w_last_beat;
    logic                w_run_complete;
    logic                w_valid;
    logic                w_busy;
    logic                w_done;
    logic [DATA_W-1:0]   w_pattern;
    logic [KEEP_W-1:0]   w_keep_last;

    assign w_start_edge   = start & ~r_start_d;
    assign w_launch       = (r_state == ST_IDLE) & w_start_edge;
    // Derived from state rather than w_valid to keep the FSM block acyclic
    assign w_hs           = (r_state == ST_SEND) & axis.tready;
    assign w_last_beat    = (r_beat_cnt == r_len);
    assign w_run_complete = (r_num != 16'd0) && (r_burst_idx == r_num);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                w_valid = 1'b1;
                w_busy  = 1'b1;
                if (w_hs && w_last_beat) begin
                    if (w_run_complete || stop) begin
                        w_state_next = ST_DONE;
                    end else if (r_gap == 8'd0) begin
                        w_state_next = ST_SEND;
                    end else begin
                        w_state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                w_busy = 1'b1;
                if (r_gap_cnt == 8'd0) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration capture, burst counters and pattern registers
    // ------------------------------------------------------------------
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_start_d    <= 1'b0;
            r_mode       <= 2'd0;
            r_len        <= 16'd0;
            r_num        <= 16'd0;
            r_gap        <= 8'd0;
            r_last_bytes <= '0;
            r_beat_cnt   <= 16'd0;
            r_burst_idx  <= 16'd0;
            r_gap_cnt    <= 8'd0;
            r_inc        <= 32'd1;
            r_walk       <= DATA_W'(1);
            r_beat_total <= 32'd0;
        end else begin
            r_start_d <= start;
            if (w_launch) begin
                r_mode       <= cfg_mode;
                r_len        <= (cfg_burst_len == 16'd0) ? 16'd1 : cfg_burst_len;
                r_num        <= cfg_num_bursts;
                r_gap        <= cfg_gap;
                r_last_bytes <= cfg_last_bytes;
                r_beat_cnt   <= 16'd1;
                r_burst_idx  <= 16'd1;
                r_gap_cnt    <= 8'd0;
                r_inc        <= 32'd1;
                r_walk       <= DATA_W'(1);
                r_beat_total <= 32'd0;
            end else begin
                if (w_hs) begin
                    r_beat_total <= r_beat_total + 32'd1;
                    r_inc        <= r_inc + 32'd1;
                    r_walk       <= {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
                    if (w_last_beat) begin
                        r_beat_cnt  <= 16'd1;
                        r_burst_idx <= r_burst_idx + 16'd1;
                        // Only consumed when the gap is non-zero
                        r_gap_cnt   <= r_gap - 8'd1;
                    end else begin
                        r_beat_cnt  <= r_beat_cnt + 16'd1;
                    end
                end
                if ((r_state == ST_GAP) && (r_gap_cnt != 8'd0)) begin
                    r_gap_cnt <= r_gap_cnt - 8'd1;
                end
            end
        end
    end

    prbs31_gen #(
        .SEED (SEED)
    ) u_prbs (
        .clk       (axis_aclk),
        .rst       (axis_areset),
        .seed_load (w_launch),
        .advance   (w_hs),
        .state     (w_prbs)
    );

    // ------------------------------------------------------------------
    // Payload selection and last-beat byte mask
    // ------------------------------------------------------------------
    always_comb begin
        w_pattern = '0;
        case (r_mode)
            MODE_INC:   w_pattern = DATA_W'(r_inc);
            MODE_WALK1: w_pattern = r_walk;
            MODE_PRBS:  w_pattern = {N_WORDS{w_prbs}};
            MODE_CONST: w_pattern = {N_WORDS{CONST_PAT}};
            default:    w_pattern = '0;
        endcase
    end

    always_comb begin
        w_keep_last = '1;
        if ((r_last_bytes != '0) && (r_last_bytes < LB_W'(KEEP_W))) begin
            w_keep_last = (KEEP_W'(1) << r_last_bytes) - KEEP_W'(1);
        end
    end

    // Payload is forced to zero outside SEND so idle/reset outputs read 0
    assign axis.tvalid = w_valid;
    assign axis.tdata  = w_valid ? w_pattern : '0;
    assign axis.tlast  = w_valid & w_last_beat;
    assign axis.tkeep  = w_valid ? (w_last_beat ? w_keep_last : '1) : '0;

    assign busy        = w_busy;
    assign done        = w_done;
    assign beat_total  = r_beat_total;

endmodule
`default_nettype wire

// File: tb/tb_axis_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pattern_gen
// Description : Self-checking bench for axis_pattern_gen. Expected beats are
//               queued when a run is launched and popped on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axis_pattern_gen;

    localparam int          DATA_W    = 256;
    localparam int          KEEP_W    = DATA_W / 8;
    localparam int          LB_W      = 6;
    localparam logic [31:0] SEED      = 32'h0000_0001;
    localparam logic [31:0] CONST_PAT = 32'hA5A5_5A5A;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic [1:0]         cfg_mode;
    logic [15:0]        cfg_burst_len;
    logic [15:0]        cfg_num_bursts;
    logic [7:0]         cfg_gap;
    logic [LB_W-1:0]    cfg_last_bytes;
    logic               busy;
    logic               done;
    logic [31:0]        beat_total;

    always #5 clk = ~clk;

    axis_pattern_gen_if #(.DATA_W(DATA_W)) axis ();

    axis_pattern_gen #(
        .DATA_W    (DATA_W),
        .SEED      (SEED),
        .CONST_PAT (CONST_PAT)
    ) dut (
        .axis_aclk      (clk),
        .axis_areset    (rst),
        .start          (start),
        .stop           (stop),
        .cfg_mode       (cfg_mode),
        .cfg_burst_len  (cfg_burst_len),
        .cfg_num_bursts (cfg_num_bursts),
        .cfg_gap        (cfg_gap),
        .cfg_last_bytes (cfg_last_bytes),
        .axis           (axis),
        .busy           (busy),
        .done           (done),
        .beat_total     (beat_total)
    );

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic              l;
    } beat_t;

    beat_t sb[$];
    int    n_err = 0;
    int    n_chk = 0;

    function automatic logic [KEEP_W-1:0] exp_keep(input int lb);
        logic [KEEP_W-1:0] m;
        m = '0;
        if (lb == 0 || lb >= KEEP_W) return '1;
        for (int i = 0; i < KEEP_W; i++) if (i < lb) m[i] = 1'b1;
        return m;
    endfunction

    // Reference model: queue every beat a run of nb bursts should produce
    task automatic push_run(input int mode, input int len, input int nb, input int lb);
        int          g;
        int          le;
        logic [31:0] lfsr;
        beat_t       b;
        lfsr = SEED;
        g    = 0;
        le   = (len == 0) ? 1 : len;
        for (int bi = 0; bi < nb; bi++) begin
            for (int i = 1; i <= le; i++) begin
                g++;
                b.d = '0;
                case (mode)
                    0: b.d[31:0] = 32'(g);
                    1: b.d[(g-1) % DATA_W] = 1'b1;
                    2: begin
                        b.d  = {(DATA_W/32){lfsr}};
                        lfsr = {lfsr[30:0], lfsr[30] ^ lfsr[27]};
                    end
                    default: b.d = {(DATA_W/32){CONST_PAT}};
                endcase
                b.l = (i == le);
                b.k = (i == le) ? exp_keep(lb) : '1;
                sb.push_back(b);
            end
        end
    endtask

    task automatic kick(input logic [1:0] m, input int len, input int nb, input int gap, input int lb);
        cfg_mode       = m;
        cfg_burst_len  = 16'(len);
        cfg_num_bursts = 16'(nb);
        cfg_gap        = 8'(gap);
        cfg_last_bytes = LB_W'(lb);
        start          = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_chk++;
            if ({axis.tvalid, axis.tlast, busy, done, axis.tkeep, axis.tdata, beat_total} !== '0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d valid=%b last=%b busy=%b done=%b keep=%h total=%0d want all 0",
                         c, axis.tvalid, axis.tlast, busy, done, axis.tkeep, beat_total);
            end
        end
    endtask

    task automatic test_inc_single();
        int    cyc, first, gaps, bad;
        beat_t got, exp;
        sb.delete();
        push_run(0, 11, 1, 0);
        axis.tready = 1'b1;
        kick(2'd0, 11, 1, 0, 0);          // start stays high for the whole run
        cyc = 0; first = -1; gaps = 0;
        do begin
            @(negedge clk); cyc++;
            if (axis.tvalid) begin
                if (first < 0) first = cyc;
                got = '{d: axis.tdata, k: axis.tkeep, l: axis.tlast};
                exp = sb.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL inc_beat got d=%h k=%h l=%b want d=%h k=%h l=%b", got.d, got.k, got.l, exp.d, exp.k, exp.l);
                end
            end else if (first >= 0) gaps++;
        end while (sb.size() > 0 && cyc < 100);
        n_chk++;
        if (first != 1) begin n_err++; $display("FAIL inc_latency first valid cycle=%0d want 1", first); end
        n_chk++;
        if (gaps != 0 || sb.size() != 0) begin
            n_err++; $display("FAIL inc_contiguous gaps=%0d left=%0d want 0/0", gaps, sb.size());
        end
        @(negedge clk);
        n_chk++;
        if ({done, busy, axis.tvalid} !== 3'b100 || beat_total !== 32'd11) begin
            n_err++; $display("FAIL inc_done done=%b busy=%b valid=%b total=%0d want 1/0/0/11", done, busy, axis.tvalid, beat_total);
        end
        bad = 0;
        repeat (5) begin @(negedge clk); if (axis.tvalid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++; end
        n_chk++;
        if (bad != 0) begin n_err++; $display("FAIL inc_no_retrigger bad_cycles=%0d want 0", bad); end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random_ready();
        int    cyc;
        bit    stalled;
        beat_t got, exp, prev;
        sb.delete();
        push_run(0, 7, 3, 0);
        kick(2'd0, 7, 3, 1, 0);
        cyc = 0; stalled = 0; prev = '0;
        do begin
            @(negedge clk); cyc++;
            start = 1'b0;
            axis.tready = 1'($urandom_range(0, 1));
            got = '{d: axis.tdata, k: axis.tkeep, l: axis.tlast};
            if (stalled) begin
                n_chk++;
                if (axis.tvalid !== 1'b1 || got !== prev) begin
                    n_err++;
                    $display("FAIL stall_hold valid=%b d=%h l=%b want 1 d=%h l=%b", axis.tvalid, got.d, got.l, prev.d, prev.l);
                end
            end
            if (axis.tvalid && axis.tready) begin
                exp = sb.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL rand_beat got d=%h k=%h l=%b want d=%h k=%h l=%b", got.d, got.k, got.l, exp.d, exp.k, exp.l);
                end
            end
            stalled = axis.tvalid && !axis.tready;
            prev    = got;
        end while (sb.size() > 0 && cyc < 500);
        axis.tready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (sb.size() != 0 || done !== 1'b1 || beat_total !== 32'd21) begin
            n_err++; $display("FAIL rand_done left=%0d done=%b total=%0d want 0/1/21", sb.size(), done, beat_total);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_gap_partial();
        int    cyc, idle, nlast;
        bit    in_gap;
        beat_t got, exp;
        sb.delete();
        push_run(0, 4, 3, 5);
        axis.tready = 1'b1;
        kick(2'd0, 4, 3, 2, 5);
        cyc = 0; idle = 0; in_gap = 0; nlast = 0;
        do begin
            @(negedge clk); cyc++;
            start = 1'b0;
            if (axis.tvalid) begin
                if (in_gap) begin
                    n_chk++;
                    if (idle != 2) begin n_err++; $display("FAIL gap_len idle=%0d want 2", idle); end
                end
                in_gap = 0;
                got = '{d: axis.tdata, k: axis.tkeep, l: axis.tlast};
                exp = sb.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL gap_beat got d=%h k=%h l=%b want d=%h k=%h l=%b", got.d, got.k, got.l, exp.d, exp.k, exp.l);
                end
                if (axis.tlast) begin
                    nlast++;
                    n_chk++;
                    if (axis.tkeep !== 32'h0000_001F) begin
                        n_err++; $display("FAIL last_keep keep=%h want 0000001f", axis.tkeep);
                    end
                    in_gap = 1; idle = 0;
                end
            end else if (in_gap) begin
                idle++;
                n_chk++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL gap_busy busy=%b want 1", busy); end
            end
        end while (sb.size() > 0 && cyc < 100);
        @(negedge clk);
        n_chk++;
        if (nlast != 3 || sb.size() != 0 || done !== 1'b1 || beat_total !== 32'd12) begin
            n_err++; $display("FAIL gap_done lasts=%0d left=%0d done=%b total=%0d want 3/0/1/12", nlast, sb.size(), done, beat_total);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_prbs_stop();
        int    cyc, hs, bad;
        beat_t got, exp;
        sb.delete();
        push_run(2, 5, 2, 0);
        axis.tready = 1'b1;
        kick(2'd2, 5, 0, 0, 0);
        cyc = 0; hs = 0;
        do begin
            @(negedge clk); cyc++;
            start = 1'b0;
            if (axis.tvalid) begin
                got = '{d: axis.tdata, k: axis.tkeep, l: axis.tlast};
                exp = sb.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL prbs_beat n=%0d got d=%h l=%b want d=%h l=%b", hs + 1, got.d, got.l, exp.d, exp.l);
                end
                hs++;
                if (hs == 7) stop = 1'b1;
            end
        end while (sb.size() > 0 && cyc < 100);
        @(negedge clk);
        n_chk++;
        if (sb.size() != 0 || done !== 1'b1 || axis.tvalid !== 1'b0 || beat_total !== 32'd10) begin
            n_err++; $display("FAIL prbs_stop_done left=%0d done=%b valid=%b total=%0d want 0/1/0/10", sb.size(), done, axis.tvalid, beat_total);
        end
        bad = 0;
        repeat (4) begin @(negedge clk); if (axis.tvalid !== 1'b0) bad++; end
        n_chk++;
        if (bad != 0) begin n_err++; $display("FAIL prbs_after_stop extra valid cycles=%0d want 0", bad); end
        stop = 1'b0;
    endtask

    task automatic test_walk_reset();
        int    cyc, hs;
        beat_t got, exp;
        // Full 300-beat run: rotation wraps from bit 255 back to bit 0
        sb.delete();
        push_run(1, 300, 1, 0);
        axis.tready = 1'b1;
        kick(2'd1, 300, 1, 0, 0);
        cyc = 0; hs = 0;
        do begin
            @(negedge clk); cyc++;
            start = 1'b0;
            if (axis.tvalid) begin
                hs++;
                got = '{d: axis.tdata, k: axis.tkeep, l: axis.tlast};
                exp = sb.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_err++; $display("FAIL walk_beat n=%0d got d=%h l=%b want d=%h l=%b", hs, got.d, got.l, exp.d, exp.l);
                end
                if (hs == 257) begin
                    n_chk++;
                    if (axis.tdata[0] !== 1'b1) begin n_err++; $display("FAIL walk_wrap bit0=%b want 1", axis.tdata[0]); end
                end
            end
        end while (sb.size() > 0 && cyc < 400);
        @(negedge clk);
        n_chk++;
        if (sb.size() != 0 || done !== 1'b1 || beat_total !== 32'd300) begin
            n_err++; $display("FAIL walk_done left=%0d done=%b total=%0d want 0/1/300", sb.size(), done, beat_total);
        end
        repeat (2) @(negedge clk);

        // Reset while beat 5 is on the bus
        sb.delete();
        push_run(1, 300, 1, 0);
        kick(2'd1, 300, 1, 0, 0);
        cyc = 0; hs = 0;
        do begin
            @(negedge clk); cyc++;
            start = 1'b0;
            if (axis.tvalid) begin
                hs++;
                exp = sb.pop_front();
                n_chk++;
                if (axis.tdata !== exp.d) begin
                    n_err++; $display("FAIL walk2_beat n=%0d got %h want %h", hs, axis.tdata, exp.d);
                end
            end
        end while (hs < 5 && cyc < 50);
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({axis.tvalid, busy, axis.tlast, done} !== 4'b0000 || axis.tdata !== '0) begin
            n_err++; $display("FAIL walk_reset valid=%b busy=%b last=%b done=%b want 0/0/0/0", axis.tvalid, busy, axis.tlast, done);
        end
        rst = 1'b0;
        @(negedge clk);

        // Restart must begin again at bit 0
        sb.delete();
        push_run(1, 3, 1, 0);
        kick(2'd1, 3, 1, 0, 0);
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            start = 1'b0;
            if (axis.tvalid) begin
                got = '{d: axis.tdata, k: axis.tkeep, l: axis.tlast};
                exp = sb.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_err++; $display("FAIL walk_restart got d=%h l=%b want d=%h l=%b", got.d, got.l, exp.d, exp.l);
                end
            end
        end while (sb.size() > 0 && cyc < 20);
        n_chk++;
        if (sb.size() != 0) begin n_err++; $display("FAIL walk_restart_timeout left=%0d want 0", sb.size()); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        stop           = 1'b0;
        cfg_mode       = 2'd0;
        cfg_burst_len  = 16'd0;
        cfg_num_bursts = 16'd0;
        cfg_gap        = 8'd0;
        cfg_last_bytes = '0;
        axis.tready    = 1'b0;
        test_reset();
        test_inc_single();
        test_random_ready();
        test_gap_partial();
        test_prbs_stop();
        test_walk_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
